vram_cmd_scheduler: RTL and testbench
=====================================

# vram_cmd_scheduler

Sequencer and arbiter in front of the VRAM/background command decoder. It shares the decoder's single 24-bit command port between CPU commands and three bulk jobs. The bulk jobs are linear memory clear (opcode 250), tile-buffer load (252) and palette-buffer load (244). For bulk jobs the block generates the `clearx`/`cleary` sweep coordinates and the per-word commands. It sits between the CPU bus bridge / stream DMA and the decoder.

## Interface
Parameters:
- `BURST`, 16: maximum consecutive job commands issued while a CPU command is pending.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_valid`  in  1  CPU command offered.
- `cpu_cmd`  in  24  CPU command, opcode in [23:16].
- `cpu_ready`  out  1  CPU command accepted this cycle when `cpu_valid && cpu_ready`.
- `job_start`  in  1  one-cycle request to start a bulk job; ignored while `busy`.
- `job_op`  in  2  0 = CLM, 1 = LOAD_BUF, 2 = LOAD_PAL, 3 = reserved (start ignored).
- `job_base`  in  13  CLM start address, sampled on `job_start`.
- `job_len`  in  14  CLM word count (0..8192), sampled on `job_start`.
- `job_abort`  in  1  terminate the active job.
- `data_valid`  in  1  stream byte available (LOAD jobs).
- `data`  in  8  stream byte.
- `data_ready`  out  1  byte consumed when `data_valid && data_ready`.
- `start`  out  1  decoder command strobe.
- `in`  out  24  decoder command word.
- `clearx`  out  6  sweep column.
- `cleary`  out  5  sweep row.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse when a job completes normally.

## Operation
- States: IDLE, CLM, LOAD, DONE.
- IDLE:
  - `job_start` with op 0 goes to CLM.
  - `job_start` with op 1 or 2 goes to LOAD. `job_op` is latched.
  - CLM with `job_len` = 0 goes directly to DONE.
- CLM:
  - One command per granted cycle: `in` = {8'd250, addr}.
  - `addr` starts at `job_base` and increments modulo 8192, for `job_len` commands. Wrap is permitted.
  - No stream data is used.
- LOAD:
  - Sweep (x, y) starts at (0, 0). `cleary` is the fast index 0..31, then `clearx` steps 0..63, for 2048 commands.
  - LOAD_BUF issues `in` = {8'd252, 8'd0, data}.
  - LOAD_PAL issues `in` = {8'd244, 12'd0, data[3:0]}.
  - A command issues only on a consumed byte. A stalled stream (`data_valid` = 0) issues nothing and holds the sweep.
- DONE: `done` = 1 for one cycle, then IDLE.
- Arbitration, evaluated every cycle; at most one command per cycle:
  - IDLE: the CPU is always granted (`cpu_ready` = 1).
  - Job active: the job wins when it has work. For CLM that is always; for LOAD it needs `data_valid`.
  - The CPU is granted in any cycle the job does not issue.
  - Fairness: when `cpu_valid` has been held through `BURST` consecutive job issues, the next cycle grants the CPU and stalls the job. In LOAD this means `data_ready` = 0 for that cycle.
  - While a job is active, CPU opcodes 244, 250 and 252 are held (`cpu_ready` = 0) until IDLE. Other opcodes pass normally.
- `job_abort`:
  - Any non-IDLE state goes to IDLE next cycle.
  - No `done` pulse; sweep/address counters are cleared.
  - A command issued in the abort cycle still completes.
- `job_start` while `busy` is ignored. Simultaneous `job_start` and `job_abort` in IDLE: the start wins.

## Timing
- Reset values: `start` = 0, `in` = 0, `clearx` = 0, `cleary` = 0, `busy` = 0, `done` = 0, `cpu_ready` = 0 during reset and 1 in IDLE afterwards, `data_ready` = 0. State = IDLE.
- `start`, `in`, `clearx` and `cleary` are registered, one-cycle latency from the grant/consume cycle. `clearx`/`cleary` are valid in the same cycle as their `start`.
- `cpu_ready` and `data_ready` are combinational from state, arbitration counter, `cpu_valid`, `data_valid` and `cpu_cmd[23:16]`.
- Job start:
  - `job_start` at cycle S makes `busy` = 1 from S+1.
  - First CLM grant is at S+1, so its `start` appears at S+2.
- Job end:
  - Last job `start` at cycle T gives `done` = 1 and `busy` = 0 at T+1.
  - A new `job_start` is accepted at T+1.
- Unstalled CLM of N words takes N+2 cycles from `job_start` to `done`.

## Structure
- Shared package `vram_pkg`:
  - Opcode constants OP_CLM = 250, OP_LOAD_BUF = 252, OP_LOAD_PAL = 244.
  - `job_op` encoding.
  - State enum.
- Sub-module `vram_sweep_counter`:
  - 13-bit counter with load, increment and terminal count.
  - Exposes {x[5:0], y[4:0]} for LOAD and a linear address for CLM.
  - Reused for both job types.
- The arbitration burst counter lives in the top module.

## Test plan
- CLM base = 8190, len = 4 → `in` = 0xFA1FFE, 0xFA1FFF, 0xFA0000, 0xFA0001 on consecutive cycles. `done` 1 cycle after the last command.
- LOAD_BUF, stream 0x00..0xFF repeating, with `data_valid` dropped for 3 cycles mid-stream → 2048 commands with no gaps besides the stall and sweep held during it. The first command has (x, y) = (0, 0); command 33 has (1, 0). The last has (63, 31) and data 0xFF.
- LOAD_PAL with data 0xA7 → `in` = 0xF40007.
- CLM len = 100 with `cpu_valid` held (opcode 6) → a CPU command is issued after every 16 job commands. Total cycles = 100 + CPU slots + 2.
- CPU opcode 250 offered during CLM → `cpu_ready` = 0 until `done`, then accepted.
- `job_abort` mid-LOAD → `busy` = 0 next cycle, no `done`. Then `rst_n` low mid-CLM → all outputs 0 asynchronously.
- CLM len = 0 → `done` at S+1, no `start`.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM command scheduler: decoder opcodes,
// bulk-job encoding and the scheduler state enum.
package vram_pkg;

  localparam logic [7:0]  OP_CLM      = 8'd250;
  localparam logic [7:0]  OP_LOAD_BUF = 8'd252;
  localparam logic [7:0]  OP_LOAD_PAL = 8'd244;

  // Last sweep index of a LOAD job: 64 columns x 32 rows.
  localparam logic [12:0] LOAD_LAST   = 13'd2047;

  typedef enum logic [1:0] {
    JOB_CLM      = 2'd0,
    JOB_LOAD_BUF = 2'd1,
    JOB_LOAD_PAL = 2'd2,
    JOB_RSVD     = 2'd3
  } job_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLM  = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Opcodes that only the bulk-job sequencer may issue while a job runs.
  function automatic logic is_job_opcode(input logic [7:0] op);
    return (op == OP_CLM) || (op == OP_LOAD_BUF) || (op == OP_LOAD_PAL);
  endfunction

endpackage

// File: rtl/vram_sweep_counter.sv
// 13-bit job index counter shared by CLM (linear address = base + index)
// and LOAD (index split into column x and fast row y).
module vram_sweep_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic        inc_i,
  input  logic [12:0] base_i,
  input  logic [12:0] last_i,
  output logic [12:0] addr_o,
  output logic [5:0]  x_o,
  output logic [4:0]  y_o,
  output logic        tc_o
);

  logic [12:0] cnt_q;
  logic [12:0] base_q;
  logic [12:0] last_q;

  // Index register: clear on abort, restart on job load, step per issued command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      base_q <= '0;
      last_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      base_q <= '0;
      last_q <= '0;
    end else if (load_i) begin
      cnt_q  <= '0;
      base_q <= base_i;
      last_q <= last_i;
    end else if (inc_i) begin
      cnt_q  <= cnt_q + 13'd1;
    end
  end

  // 13-bit sum wraps modulo 8192, which is the intended CLM address wrap.
  assign addr_o = base_q + cnt_q;
  assign y_o    = cnt_q[4:0];
  assign x_o    = cnt_q[10:5];
  assign tc_o   = (cnt_q == last_q);

endmodule

// File: rtl/vram_cmd_scheduler.sv
// Arbiter/sequencer sharing the decoder command port between CPU commands
// and the CLM / LOAD_BUF / LOAD_PAL bulk jobs.
module vram_cmd_scheduler
  import vram_pkg::*;
#(
  parameter int BURST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  input  logic [23:0] cpu_cmd,
  output logic        cpu_ready,
  input  logic        job_start,
  input  logic [1:0]  job_op,
  input  logic [12:0] job_base,
  input  logic [13:0] job_len,
  input  logic        job_abort,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic        data_ready,
  output logic        start,
  output logic [23:0] in,
  output logic [5:0]  clearx,
  output logic [4:0]  cleary,
  output logic        busy,
  output logic        done
);

  localparam int BW = $clog2(BURST + 1);

  state_e        state_q;
  job_op_e       op_q;
  logic [BW-1:0] burst_q, burst_d;
  logic          start_q, busy_q, done_q;
  logic [23:0]   in_q;
  logic [5:0]    clearx_q;
  logic [4:0]    cleary_q;

  logic          start_ok, cnt_load, cnt_clr;
  logic [12:0]   cnt_base, cnt_last, sw_addr;
  logic [5:0]    sw_x;
  logic [4:0]    sw_y;
  logic          sw_tc;
  logic          job_work, cpu_hold, fair_stall, job_issue, cpu_fire;
  logic          cpu_ready_c, data_ready_c;
  logic [23:0]   job_word;

  assign start_ok = job_start && (job_op != JOB_RSVD);
  assign cnt_load = (state_q == ST_IDLE) && start_ok;
  assign cnt_clr  = job_abort && (state_q != ST_IDLE);
  assign cnt_base = (job_op == JOB_CLM) ? job_base : 13'd0;
  // job_len = 8192 has [12:0] = 0, so the subtraction wraps to 8191 as needed.
  assign cnt_last = (job_op == JOB_CLM) ? (job_len[12:0] - 13'd1) : LOAD_LAST;

  vram_sweep_counter u_sweep (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .clr_i  (cnt_clr),
    .inc_i  (job_issue),
    .base_i (cnt_base),
    .last_i (cnt_last),
    .addr_o (sw_addr),
    .x_o    (sw_x),
    .y_o    (sw_y),
    .tc_o   (sw_tc)
  );

  // Per-cycle arbitration: job first, CPU on any free slot, burst limit for fairness.
  always_comb begin
    job_work     = (state_q == ST_CLM) || ((state_q == ST_LOAD) && data_valid);
    cpu_hold     = (state_q != ST_IDLE) && is_job_opcode(cpu_cmd[23:16]);
    fair_stall   = job_work && cpu_valid && !cpu_hold && (burst_q == BW'(BURST));
    job_issue    = job_work && !fair_stall;
    cpu_ready_c  = rst_n && !job_issue && !cpu_hold;
    data_ready_c = rst_n && (state_q == ST_LOAD) && !fair_stall;
    cpu_fire     = cpu_valid && cpu_ready_c;

    burst_d = burst_q;
    if ((state_q == ST_IDLE) || !cpu_valid || cpu_fire) begin
      burst_d = '0;
    end else if (job_issue && !cpu_hold) begin
      burst_d = burst_q + BW'(1);
    end

    job_word = {OP_CLM, 3'b000, sw_addr};
    if (state_q == ST_LOAD) begin
      if (op_q == JOB_LOAD_PAL) begin
        job_word = {OP_LOAD_PAL, 12'h000, data[3:0]};
      end else begin
        job_word = {OP_LOAD_BUF, 8'h00, data};
      end
    end
  end

  // Job FSM with registered command port, sweep coordinates and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= JOB_CLM;
      burst_q  <= '0;
      start_q  <= 1'b0;
      in_q     <= '0;
      clearx_q <= '0;
      cleary_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      burst_q <= burst_d;
      start_q <= job_issue || cpu_fire;
      if (job_issue) begin
        in_q     <= job_word;
        clearx_q <= sw_x;
        cleary_q <= sw_y;
      end else if (cpu_fire) begin
        in_q     <= cpu_cmd;
      end

      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            op_q <= job_op_e'(job_op);
            if ((job_op == JOB_CLM) && (job_len == 14'd0)) begin
              // Empty clear: pulse done straight away, never become busy.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= (job_op == JOB_CLM) ? ST_CLM : ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_CLM, ST_LOAD: begin
          if (job_abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (job_issue && sw_tc) begin
            // Stay busy while the last command is on the port.
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Normal end pulses done now; the empty-clear path already pulsed.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= job_abort ? 1'b0 : !done_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ready  = cpu_ready_c;
  assign data_ready = data_ready_c;
  assign start      = start_q;
  assign in         = in_q;
  assign clearx     = clearx_q;
  assign cleary     = cleary_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vram_cmd_scheduler.sv
// Directed bench for vram_cmd_scheduler: CLM, LOAD_BUF with stall,
// LOAD_PAL + abort, CPU fairness, held opcodes, empty clear and reset.
module tb_vram_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid;
  logic [23:0] cpu_cmd;
  logic        cpu_ready;
  logic        job_start;
  logic [1:0]  job_op;
  logic [12:0] job_base;
  logic [13:0] job_len;
  logic        job_abort;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_ready;
  logic        start;
  logic [23:0] in;
  logic [5:0]  clearx;
  logic [4:0]  cleary;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  vram_cmd_scheduler #(.BURST(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_valid  (cpu_valid),
    .cpu_cmd    (cpu_cmd),
    .cpu_ready  (cpu_ready),
    .job_start  (job_start),
    .job_op     (job_op),
    .job_base   (job_base),
    .job_len    (job_len),
    .job_abort  (job_abort),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .start      (start),
    .in         (in),
    .clearx     (clearx),
    .cleary     (cleary),
    .busy       (busy),
    .done       (done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [23:0] cmd_q[$];
  logic [10:0] xy_q[$];
  int          cyc_q[$];
  logic [23:0] exp_q[$];
  int          byte_idx, stall_left, cpu_acc, cpu_acc_cyc;
  logic        busy1;

  function automatic logic [31:0] cmd_at(input int i);
    return (i < cmd_q.size()) ? {8'h00, cmd_q[i]} : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] xy_at(input int i);
    return (i < xy_q.size()) ? {21'h0, xy_q[i]} : 32'hDEAD_BEEF;
  endfunction
  function automatic int cyc_at(input int i);
    return (i < cyc_q.size()) ? cyc_q[i] : -1000;
  endfunction

  // Runs one job after job_start was driven; cycles counts negedges until done.
  task automatic run_job(input int budget, input bit stream_on, input int stall_at,
                         input int cpu_from, output int cycles);
    bit got_done;
    got_done = 1'b0;
    cycles   = 0;
    cmd_q.delete(); xy_q.delete(); cyc_q.delete();
    byte_idx = 0; stall_left = 3; cpu_acc = 0; cpu_acc_cyc = -1; busy1 = 1'b0;
    while (!got_done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) busy1 = busy;
      if (start) begin
        cmd_q.push_back(in);
        xy_q.push_back({clearx, cleary});
        cyc_q.push_back(cycles);
      end
      if (done) got_done = 1'b1;
      job_start = 1'b0;
      if (cycles == cpu_from) cpu_valid = 1'b1;
      if (stream_on) begin
        if (byte_idx == stall_at && stall_left > 0) begin
          data_valid = 1'b0;
          stall_left--;
        end else begin
          data_valid = (byte_idx < 2048);
        end
        data = byte_idx[7:0];
      end
      #1;
      if (cpu_valid && cpu_ready) begin
        cpu_acc++;
        if (cpu_acc_cyc < 0) cpu_acc_cyc = cycles;
      end
      if (data_valid && data_ready) byte_idx++;
    end
    if (!got_done) chk("job_timeout", 32'd0, 32'd1);
    data_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    int nclm;
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_cmd = '0; job_start = 1'b0; job_op = '0;
    job_base = '0; job_len = '0; job_abort = 1'b0; data_valid = 1'b0; data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_in", 32'(in), 32'd0);
    chk("rst_xy", 32'({clearx, cleary}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_ready", 32'({cpu_ready, data_ready}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_cpu_ready", 32'(cpu_ready), 32'd1);

    // CLM base 8190 len 4 with address wrap
    @(negedge clk);
    job_start = 1'b1; job_op = 2'd0; job_base = 13'd8190; job_len = 14'd4;
    run_job(50, 1'b0, 0, 0, cyc);
    chk("clm4_busy_s1", 32'(busy1), 32'd1);
    chk("clm4_cycles", 32'(cyc), 32'd6);
    chk("clm4_count", 32'(cmd_q.size()), 32'd4);
    chk("clm4_cmd0", cmd_at(0), 32'hFA1FFE);
    chk("clm4_cmd1", cmd_at(1), 32'hFA1FFF);
    chk("clm4_cmd2", cmd_at(2), 32'hFA0000);
    chk("clm4_cmd3", cmd_at(3), 32'hFA0001);
    chk("clm4_first_at", 32'(cyc_at(0)), 32'd2);
    chk("clm4_last_at", 32'(cyc_at(3)), 32'd5);
    chk("clm4_idle_busy", 32'(busy), 32'd0);

    // CLM len 0: done next cycle, nothing issued
    @(negedge clk);
    job_start = 1'b1; job_op = 2'd0; job_base = 13'd77; job_len = 14'd0;
    run_job(10, 1'b0, 0, 0, cyc);
    chk("clm0_cycles", 32'(cyc), 32'd1);
    chk("clm0_count", 32'(cmd_q.size()), 32'd0);

    // Reserved op is ignored
    @(negedge clk);
    job_start = 1'b1; job_op = 2'd3;
    @(negedge clk);
    job_start = 1'b0;
    chk("rsvd_busy", 32'({busy, done}), 32'd0);

    // LOAD_BUF, byte stream 0..255 repeating, 3-cycle stall before byte 100
    @(negedge clk);
    job_start = 1'b1; job_op = 2'd1;
    run_job(3000, 1'b1, 100, 0, cyc);
    chk("lbuf_cycles", 32'(cyc), 32'd2053);
    chk("lbuf_count", 32'(cmd_q.size()), 32'd2048);
    chk("lbuf_cmd0", cmd_at(0), 32'hFC0000);
    chk("lbuf_xy0", xy_at(0), 32'd0);
    chk("lbuf_cmd32", cmd_at(32), 32'hFC0020);
    chk("lbuf_xy32", xy_at(32), 32'({6'd1, 5'd0}));
    chk("lbuf_xy100", xy_at(100), 32'({6'd3, 5'd4}));
    chk("lbuf_stall_gap", 32'(cyc_at(100) - cyc_at(99)), 32'd4);
    chk("lbuf_span", 32'(cyc_at(2047) - cyc_at(0)), 32'd2050);
    chk("lbuf_last", cmd_at(2047), 32'hFC00FF);
    chk("lbuf_xylast", xy_at(2047), 32'({6'd63, 5'd31}));
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (cmd_at(i) !== {8'h00, 8'hFC, 8'h00, 8'(i)}) bad++;
      if (xy_at(i) !== {21'h0, 6'(i / 32), 5'(i % 32)}) bad++;
    end
    chk("lbuf_all", 32'(bad), 32'd0);

    // LOAD_PAL with data 0xA7, then abort mid-job
    @(negedge clk);
    job_start = 1'b1; job_op = 2'd2;
    @(negedge clk);
    job_start = 1'b0;
    chk("lpal_busy", 32'(busy), 32'd1);
    data_valid = 1'b1; data = 8'hA7;
    @(negedge clk);
    chk("lpal_start", 32'(start), 32'd1);
    chk("lpal_cmd", 32'(in), 32'hF40007);
    chk("lpal_xy0", 32'({clearx, cleary}), 32'd0);
    @(negedge clk);
    chk("lpal_y1", 32'(cleary), 32'd1);
    job_abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_last_cmd", 32'({start, cleary}), 32'({1'b1, 5'd2}));
    chk("abort_no_done", 32'(done), 32'd0);
    job_abort = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({start, done, data_ready}), 32'd0);

    // CLM len 100 with CPU opcode 6 held valid: CPU slot after every 16 jobs
    @(negedge clk);
    cpu_valid = 1'b1; cpu_cmd = 24'h061234;
    job_start = 1'b1; job_op = 2'd0; job_base = 13'h0100; job_len = 14'd100;
    run_job(400, 1'b0, 0, 0, cyc);
    cpu_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(24'h061234);
    for (int j = 0; j < 100; j++) begin
      exp_q.push_back({8'hFA, 3'b000, 13'(13'h0100 + j)});
      if ((j + 1) % 16 == 0 && j != 99) exp_q.push_back(24'h061234);
    end
    exp_q.push_back(24'h061234);
    chk("fair_cycles", 32'(cyc), 32'd108);
    chk("fair_count", 32'(cmd_q.size()), 32'(exp_q.size()));
    bad = 0;
    nclm = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cmd_at(i) !== {8'h00, exp_q[i]}) bad++;
      if (cmd_at(i) !== 32'h061234) nclm++;
    end
    chk("fair_sequence", 32'(bad), 32'd0);
    chk("fair_clm_count", 32'(nclm), 32'd100);
    chk("fair_cpu_slot", cmd_at(17), 32'h061234);

    // CPU opcode 250 during CLM is held until the job ends
    @(negedge clk);
    cpu_cmd = 24'hFA0ABC;
    job_start = 1'b1; job_op = 2'd0; job_base = 13'd0; job_len = 14'd4;
    run_job(50, 1'b0, 0, 1, cyc);
    chk("hold_cycles", 32'(cyc), 32'd6);
    chk("hold_first_accept", 32'(cpu_acc_cyc), 32'd6);
    chk("hold_job_count", 32'(cmd_q.size()), 32'd4);
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    @(negedge clk);
    chk("hold_issued", 32'({start, in}), 32'({1'b1, 24'hFA0ABC}));

    // Asynchronous reset in the middle of a CLM
    @(negedge clk);
    job_start = 1'b1; job_op = 2'd0; job_base = 13'd5; job_len = 14'd50;
    @(negedge clk);
    job_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_clm_active", 32'({start, busy}), 32'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd", 32'({start, in}), 32'd0);
    chk("async_rst_stat", 32'({busy, done, cpu_ready, data_ready, clearx, cleary}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'({busy, start, cpu_ready}), 32'b001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
